mux2_sel_arbiter: RTL and testbench

Two-requester round-robin arbiter that generates the select line for the downstream 2:1 multiplexer (`sel` drives the mux `sel` input; requester 0 owns mux input `in0`, requester 1 owns `in1`). It grants at most one requester at a time and bounds each grant tenure to `HOLD` cycles when the other side is waiting. All outputs are registered, so the mux select is glitch-free and changes only on clock edges.

---
 rtl/mux2_sel_arbiter.sv | 138 +++++++++++++
 tb/tb_mux2_sel_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mux2_sel_arbiter.sv
// mux2_sel_arbiter: two-requester round-robin arbiter driving the select
// line of a downstream 2:1 mux. A grant tenure is bounded to HOLD cycles
// while the other requester waits. All outputs are registered, so the mux
// select only changes on clock edges.
module mux2_sel_arbiter #(
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          sel,
  output logic          valid,
  output logic [CW-1:0] tenure
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G0   = 2'd1,
    S_G1   = 2'd2
  } state_t;

  // Last tenure index; reaching it ends the tenure (handover or restart).
  localparam logic [CW-1:0] LP_TMAX = CW'(HOLD - 1);

  state_t        r_state;
  logic          r_last;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_sel;
  logic          r_valid;
  logic [CW-1:0] r_tenure;

  state_t        w_nxt_state;
  logic          w_clr_tenure;
  logic          w_at_max;

  assign w_at_max = (r_tenure == LP_TMAX);

  // Next-state decision from the sampled requests; also flags every case
  // where the tenure counter must restart at 0.
  always_comb begin
    w_nxt_state  = r_state;
    w_clr_tenure = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clr_tenure = 1'b1;
        if (req0 && req1) begin
          // Contended: the side that was not granted most recently wins.
          w_nxt_state = r_last ? S_G0 : S_G1;
        end else if (req0) begin
          w_nxt_state = S_G0;
        end else if (req1) begin
          w_nxt_state = S_G1;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_G0: begin
        if (!req0) begin
          w_nxt_state  = req1 ? S_G1 : S_IDLE;
          w_clr_tenure = 1'b1;
        end else if (w_at_max) begin
          // Tenure exhausted: hand over if the other side waits, otherwise
          // keep the grant and begin a fresh tenure.
          w_nxt_state  = req1 ? S_G1 : S_G0;
          w_clr_tenure = 1'b1;
        end else begin
          w_nxt_state  = S_G0;
        end
      end
      S_G1: begin
        if (!req1) begin
          w_nxt_state  = req0 ? S_G0 : S_IDLE;
          w_clr_tenure = 1'b1;
        end else if (w_at_max) begin
          w_nxt_state  = req0 ? S_G0 : S_G1;
          w_clr_tenure = 1'b1;
        end else begin
          w_nxt_state  = S_G1;
        end
      end
      default: begin
        w_nxt_state  = S_IDLE;
        w_clr_tenure = 1'b1;
      end
    endcase
  end

  // State register with outputs decoded from the next state, so every
  // output is a flop and grant/select move together on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_sel    <= 1'b0;
      r_valid  <= 1'b0;
      r_tenure <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_tenure <= w_clr_tenure ? '0 : r_tenure + 1'b1;
      case (w_nxt_state)
        S_G0: begin
          r_gnt0  <= 1'b1;
          r_gnt1  <= 1'b0;
          r_sel   <= 1'b0;
          r_valid <= 1'b1;
          if (r_state != S_G0) r_last <= 1'b0;
        end
        S_G1: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b1;
          r_sel   <= 1'b1;
          r_valid <= 1'b1;
          if (r_state != S_G1) r_last <= 1'b1;
        end
        default: begin
          // Idle: no grant; sel keeps pointing at the last granted input.
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign sel    = r_sel;
  assign valid  = r_valid;
  assign tenure = r_tenure;

endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// Scoreboard bench for mux2_sel_arbiter: a default (HOLD=4) instance and a
// HOLD=1 instance, driven by directed vectors with hand-computed results.
module tb_mux2_sel_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // HOLD=4 instance
  logic       rst_a = 1'b1, req0_a = 1'b0, req1_a = 1'b0;
  logic       gnt0_a, gnt1_a, sel_a, valid_a;
  logic [7:0] ten_a;

  // HOLD=1 instance
  logic       rst_b = 1'b1, req0_b = 1'b0, req1_b = 1'b0;
  logic       gnt0_b, gnt1_b, sel_b, valid_b;
  logic [7:0] ten_b;

  mux2_sel_arbiter #(.HOLD(4), .CW(8)) u_dut_a (
    .clk(clk), .rst(rst_a), .req0(req0_a), .req1(req1_a),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a), .valid(valid_a), .tenure(ten_a)
  );

  mux2_sel_arbiter #(.HOLD(1), .CW(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .req0(req0_b), .req1(req1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b), .valid(valid_b), .tenure(ten_b)
  );

  typedef struct {
    int         which;
    string      name;
    logic [11:0] exp;   // {gnt0, gnt1, sel, valid, tenure[7:0]}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Drive one cycle of inputs, then queue the outputs expected after the edge.
  task automatic step(input int which, input string nm, input logic r,
                      input logic q0, input logic q1, input logic g0,
                      input logic g1, input logic s, input int t);
    exp_t e;
    @(negedge clk);
    if (which == 0) begin
      rst_a = r; req0_a = q0; req1_a = q1;
    end else begin
      rst_b = r; req0_b = q0; req1_b = q1;
    end
    @(posedge clk);
    e.which = which;
    e.name  = nm;
    e.exp   = {g0, g1, s, (g0 | g1), 8'(t)};
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle and compares away from the edge.
  initial begin
    exp_t        e;
    logic [11:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.which == 0) got = {gnt0_a, gnt1_a, sel_a, valid_a, ten_a};
        else              got = {gnt0_b, gnt1_b, sel_b, valid_b, ten_b};
        n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got g0/g1/sel/vld=%b tenure=%0d, required g0/g1/sel/vld=%b tenure=%0d",
                   e.name, got[11:8], got[7:0], e.exp[11:8], e.exp[7:0]);
        end
      end
    end
  end

  initial begin
    // ---- HOLD=4: reset, then continuous contention ----
    step(0, "reset",          1, 0, 0, 0, 0, 0, 0);
    step(0, "rst_over_req",   1, 1, 1, 0, 0, 0, 0);
    step(0, "both_g0_t0",     0, 1, 1, 1, 0, 0, 0);
    step(0, "both_g0_t1",     0, 1, 1, 1, 0, 0, 1);
    step(0, "both_g0_t2",     0, 1, 1, 1, 0, 0, 2);
    step(0, "both_g0_t3",     0, 1, 1, 1, 0, 0, 3);
    step(0, "both_g1_t0",     0, 1, 1, 0, 1, 1, 0);
    step(0, "both_g1_t1",     0, 1, 1, 0, 1, 1, 1);
    step(0, "both_g1_t2",     0, 1, 1, 0, 1, 1, 2);
    step(0, "both_g1_t3",     0, 1, 1, 0, 1, 1, 3);
    step(0, "both_g0_again",  0, 1, 1, 1, 0, 0, 0);
    step(0, "both_g0_again1", 0, 1, 1, 1, 0, 0, 1);
    // ---- only req1: tenure restarts without a gap ----
    step(0, "reset2",         1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(0, $sformatf("solo1_%0d", i), 0, 0, 1, 0, 1, 1, i % 4);
    // ---- release to idle, sel holds, contended grant goes to 0 ----
    step(0, "idle_sel_hold",  0, 0, 0, 0, 0, 1, 0);
    step(0, "idle_sel_hold2", 0, 0, 0, 0, 0, 1, 0);
    step(0, "idle_both_g0",   0, 1, 1, 1, 0, 0, 0);
    step(0, "g0_t1",          0, 1, 1, 1, 0, 0, 1);
    step(0, "drop0_handover", 0, 0, 1, 0, 1, 1, 0);
    step(0, "g1_t1",          0, 1, 1, 0, 1, 1, 1);
    step(0, "g1_t2",          0, 1, 1, 0, 1, 1, 2);
    step(0, "rst_mid_g1",     1, 1, 1, 0, 0, 0, 0);
    step(0, "post_rst_g0",    0, 1, 1, 1, 0, 0, 0);
    step(0, "g0_release",     0, 0, 0, 0, 0, 0, 0);
    step(0, "idle_both_g1",   0, 1, 1, 0, 1, 1, 0);
    step(0, "g1_release",     0, 0, 0, 0, 0, 1, 0);
    step(0, "solo0_g0",       0, 1, 0, 1, 0, 0, 0);
    step(0, "ungranted_drop", 0, 1, 0, 1, 0, 0, 1);
    // ---- HOLD=1: alternation every cycle ----
    step(1, "h1_reset",       1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step(1, $sformatf("h1_alt_%0d", i), 0, 1, 1, i % 2 == 0, i % 2 == 1, i % 2 == 1, 0);
    step(1, "h1_solo0",       0, 1, 0, 1, 0, 0, 0);
    step(1, "h1_solo0_keep",  0, 1, 0, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued entries, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
